cube_root_seq: RTL and testbench



---
 rtl/cube_root_pkg.sv | 27 ++
 rtl/cube_root_bcd10.sv | 46 ++++
 rtl/cube_root_seq.sv | 143 ++++++++++++++
 tb/tb_cube_root_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cube_root_pkg.sv
// Shared types and constants for the sequential cube-root block.
// Contents: FSM state enum, scaling/iteration constants, datapath widths.
package cube_root_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ITER,
      ST_CONV,
      ST_DONE
   } state_t;

   localparam int unsigned SCALE      = 1_000_000;
   localparam int unsigned ITER_COUNT = 11;
   localparam int unsigned S_INIT     = 30;
   localparam int unsigned S_STEP     = 3;
   localparam int unsigned BCD_STEPS  = 10;

   localparam int X_W = 32;
   localparam int Y_W = 10;
   localparam int B_W = 64;
   localparam int S_W = 6;

   // Shift amount used by the final iteration; reaching it ends ITER.
   localparam int unsigned S_LAST = S_INIT - (ITER_COUNT - 1) * S_STEP;

endpackage

// File: rtl/cube_root_bcd10.sv
// Sequential double-dabble: 10-bit binary to three BCD digits, one bit per step.
// Ports:
//   clk, rst  - clock, async active-high reset
//   load      - capture bin_in and clear the BCD accumulator
//   step      - perform one add-3/shift step
//   bin_in    - 10-bit binary value (0..999 converts correctly)
//   digits    - {hundreds, tens, units} as the accumulator will read after the
//               next step; after BCD_STEPS-1 steps this is the final result
module cube_root_bcd10
   import cube_root_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            step,
   input  logic [Y_W-1:0]  bin_in,
   output logic [11:0]     digits
);

   logic [Y_W-1:0] bin_q;
   logic [11:0]    bcd_q;
   logic [11:0]    bcd_adj;

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      digits = {bcd_adj[10:0], bin_q[Y_W-1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q <= '0;
         bcd_q <= '0;
      end else if (load) begin
         bin_q <= bin_in;
         bcd_q <= '0;
      end else if (step) begin
         bcd_q <= digits;
         bin_q <= {bin_q[Y_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/cube_root_seq.sv
// Sequential cube root of an 8-bit operand to two fractional decimal digits.
// Result d2.d1d0 = floor(cbrt(number * 1e6)) / 100, delivered as BCD.
// Ports:
//   clk, rst          - clock, async active-high reset
//   number[7:0]       - operand, sampled on the edge that accepts start
//   start             - request, accepted in IDLE
//   busy              - high in LOAD, ITER, CONV
//   done              - one-cycle pulse in DONE
//   valid             - dig2..dig0 hold a completed result
//   dig2, dig1, dig0  - BCD result digits
// Build option: CUBE_ROOT_SEQ_ABORT_EN - start while busy restarts the operation;
// when undefined, start is ignored while busy.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | x/y/s freshly initialised; performs the first root-digit step
// ITER  | remaining root-digit steps, one per cycle
// CONV  | binary root shifting through the double-dabble
// DONE  | result published, done pulse
module cube_root_seq
   import cube_root_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] number,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       valid,
   output logic [3:0] dig2,
   output logic [3:0] dig1,
   output logic [3:0] dig0
);

   state_t         state, state_nxt;
   logic [X_W-1:0] x, x_step;
   logic [Y_W-1:0] y, y2, y_step;
   logic [S_W-1:0] s;
   logic [3:0]     cnt;
   logic [B_W-1:0] b;
   logic           take;
   logic           accept, abort, load_op;
   logic           iter_last, conv_last;
   logic [11:0]    bcd_digits;

   assign accept = (state == ST_IDLE) && start;
`ifdef CUBE_ROOT_SEQ_ABORT_EN
   assign abort  = start && ((state == ST_LOAD) || (state == ST_ITER) || (state == ST_CONV));
`else
   assign abort  = 1'b0;
`endif
   assign load_op   = accept || abort;
   assign iter_last = (state == ST_ITER) && (s == S_W'(S_LAST));
   assign conv_last = (state == ST_CONV) && (cnt == 4'd0);

   // One restoring step of the digit-by-digit cube root. Widened to 64 bits so
   // (3y(y+1)+1) << 30 never truncates.
   always_comb begin
      y2     = y << 1;
      b      = (B_W'(3) * B_W'(y2) * (B_W'(y2) + B_W'(1)) + B_W'(1)) << s;
      take   = B_W'(x) >= b;
      y_step = take ? (y2 + Y_W'(1)) : y2;
      x_step = take ? (x - b[X_W-1:0]) : x;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_LOAD;
         ST_LOAD: begin
            busy      = 1'b1;
            state_nxt = ST_ITER;
         end
         ST_ITER: begin
            busy = 1'b1;
            if (iter_last) state_nxt = ST_CONV;
         end
         ST_CONV: begin
            busy = 1'b1;
            if (conv_last) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (abort) state_nxt = ST_LOAD;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         x     <= '0;
         y     <= '0;
         s     <= '0;
         cnt   <= '0;
         valid <= 1'b0;
         dig2  <= '0;
         dig1  <= '0;
         dig0  <= '0;
      end else begin
         state <= state_nxt;

         if (load_op) begin
            x     <= X_W'(number) * SCALE;
            y     <= '0;
            s     <= S_W'(S_INIT);
            valid <= 1'b0;
         end else if ((state == ST_LOAD) || (state == ST_ITER)) begin
            x <= x_step;
            y <= y_step;
            s <= s - S_W'(S_STEP);
         end

         if (iter_last && !abort)
            cnt <= 4'(BCD_STEPS - 1);
         else if (state == ST_CONV)
            cnt <= cnt - 4'd1;

         if (conv_last && !abort) begin
            dig2  <= bcd_digits[11:8];
            dig1  <= bcd_digits[7:4];
            dig0  <= bcd_digits[3:0];
            valid <= 1'b1;
         end
      end
   end

   // The converter is loaded with the root produced by the final step so that
   // shifting starts on the very next edge.
   cube_root_bcd10 u_bcd (
      .clk    (clk),
      .rst    (rst),
      .load   (iter_last),
      .step   (state == ST_CONV),
      .bin_in (y_step),
      .digits (bcd_digits)
   );

endmodule

// File: tb/tb_cube_root_seq.sv
module tb_cube_root_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] number;
   logic       start;
   logic       busy, done, valid;
   logic [3:0] dig2, dig1, dig0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cube_root_seq dut (
      .clk    (clk),
      .rst    (rst),
      .number (number),
      .start  (start),
      .busy   (busy),
      .done   (done),
      .valid  (valid),
      .dig2   (dig2),
      .dig1   (dig1),
      .dig0   (dig0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Largest r with r^3 <= n*1e6, found by plain search.
   function automatic int ref_root(input int n);
      longint t;
      longint r;
      t = longint'(n) * 64'd1000000;
      r = 0;
      while ((r + 1) * (r + 1) * (r + 1) <= t) r++;
      return int'(r);
   endfunction

   function automatic logic [11:0] ref_bcd(input int n);
      int r;
      r = ref_root(n);
      return {4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
   endfunction

   // Drives one start request; returns #1 after the accepting edge.
   task automatic start_op(input logic [7:0] n);
      @(negedge clk);
      number = n;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      number = 8'($urandom);
   endtask

   // Continues from k0 edges after the accepting edge and expects done on the
   // 21st edge after it with the result for n.
   task automatic finish_op(input string tag, input logic [7:0] n, input int k0);
      int k;
      int busy_cnt;
      busy_cnt = k0 + 1;
      k = k0;
      while (k < 40) begin
         @(posedge clk);
         #1;
         k++;
         if (done === 1'b1) break;
         if (busy === 1'b1) busy_cnt++;
      end
      check({tag, "_latency"}, k, 21);
      check({tag, "_busy_cycles"}, busy_cnt, 21);
      check({tag, "_digits"}, {dig2, dig1, dig0}, ref_bcd(int'(n)));
      check({tag, "_valid"}, valid, 1);
      @(posedge clk);
      #1;
      check({tag, "_done_single"}, done, 0);
   endtask

   task automatic run_op(input string tag, input logic [7:0] n);
      start_op(n);
      check({tag, "_accept_busy"}, busy, 1);
      check({tag, "_accept_valid"}, valid, 0);
      finish_op(tag, n, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int done_edges[$];
      logic [7:0] rn;
      int seen_done;

      rst    = 1'b1;
      start  = 1'b0;
      number = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", {busy, done, valid, dig2, dig1, dig0}, 0);
      @(negedge clk);
      rst = 1'b0;

      run_op("n8", 8'd8);
      run_op("n255", 8'd255);
      run_op("n100", 8'd100);
      run_op("n0", 8'd0);
      run_op("n1", 8'd1);

      for (int i = 0; i < 15; i++) begin
         rn = 8'($urandom_range(0, 255));
         run_op("rand", rn);
      end

      // Operand change after acceptance must not leak into the result.
      start_op(8'd27);
      repeat (3) @(posedge clk);
      #1;
      number = 8'd200;
      finish_op("n27_chg", 8'd27, 3);

      // Reset in the middle of ITER.
      start_op(8'd125);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_outs", {busy, done, valid, dig2, dig1, dig0}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen_done = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) seen_done++;
      end
      check("rst_mid_no_done", seen_done, 0);
      check("rst_mid_valid", valid, 0);
      run_op("after_rst_n64", 8'd64);

      // start re-pulsed during CONV.
      start_op(8'd50);
      repeat (15) @(posedge clk);
      @(negedge clk);
      number = 8'd125;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
`ifdef CUBE_ROOT_SEQ_ABORT_EN
      check("abort_valid_cleared", valid, 0);
      finish_op("abort", 8'd125, 0);
`else
      finish_op("noabort", 8'd50, 16);
`endif

      // start held high: a new accept every 23 edges.
      @(negedge clk);
      number = 8'd200;
      start  = 1'b1;
      @(posedge clk);
      #1;
      for (int e = 1; e <= 70; e++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            done_edges.push_back(e);
            check("b2b_digits", {dig2, dig1, dig0}, ref_bcd(200));
         end
         if (e == 23 || e == 46) check("b2b_valid_low", valid, 0);
      end
      start = 1'b0;
      check("b2b_done_count", done_edges.size(), 3);
      for (int j = 0; j < done_edges.size() && j < 3; j++)
         check("b2b_done_edge", done_edges[j], 21 + 23 * j);

      repeat (30) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
